// File: rtl/id_ex_control_stage_if.sv
// id_ex_control_stage_if: ID-side request and registered ID/EX control bundle
interface id_ex_control_stage_if;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        flush;
   logic        id_ready;
   logic        ex_valid;
   logic        ex_hold;
   logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
   logic        ex_Branch, ex_JalrSel, ex_Jump;
   logic [1:0]  ex_ALUOp;
   logic        ex_lui, ex_auipc, ex_muldiv, ex_illegal;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   modport master (
      output id_valid, id_instr, flush,
      input  id_ready, ex_valid, ex_hold, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_Branch, ex_JalrSel, ex_Jump, ex_ALUOp, ex_lui, ex_auipc,
             ex_muldiv, ex_illegal, ex_rd, ex_rs1, ex_rs2
   );
   modport slave (
      input  id_valid, id_instr, flush,
      output id_ready, ex_valid, ex_hold, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
             ex_MemWrite, ex_Branch, ex_JalrSel, ex_Jump, ex_ALUOp, ex_lui, ex_auipc,
             ex_muldiv, ex_illegal, ex_rd, ex_rs1, ex_rs2
   );
endinterface

// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage: RV32 ID decode into the ID/EX register with load-use and MUL/DIV stalls
module id_ex_control_stage #(
   parameter bit MULDIV_EN  = 1'b1,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 33
) (
   input logic clk,
   input logic reset,
   id_ex_control_stage_if.slave bus
);
   localparam int MAX_C = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_C) + 1;
   localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef struct packed {
      logic       valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, jalrsel, jump;
      logic [1:0] aluop;
      logic       lui, auipc, muldiv, illegal;
      logic [4:0] rd, rs1, rs2;
   } ex_t;
   state_t state;
   logic [CW-1:0] cnt, ld;
   ex_t ex, dec;
   logic [6:0] op;
   logic is_r, is_ld, is_st, is_br, is_imm, is_jal, is_jalr, is_lui, is_aui;
   logic md, illegal, use1, use2, luse, busy, unused_f3;
   assign op      = bus.id_instr[6:0];
   assign is_r    = op == 7'b0110011;
   assign is_ld   = op == 7'b0000011;
   assign is_st   = op == 7'b0100011;
   assign is_br   = op == 7'b1100011;
   assign is_imm  = op == 7'b0010011;
   assign is_jal  = op == 7'b1101111;
   assign is_jalr = op == 7'b1100111;
   assign is_lui  = op == 7'b0110111;
   assign is_aui  = op == 7'b0010111;
   assign md      = is_r & (bus.id_instr[31:25] == 7'b0000001);
   assign illegal = !(is_r | is_ld | is_st | is_br | is_imm | is_jal | is_jalr | is_lui | is_aui)
                    | (md & !MULDIV_EN);
   assign use1    = is_r | is_ld | is_st | is_br | is_imm | is_jalr;
   assign use2    = is_r | is_st | is_br;
   assign ld      = bus.id_instr[14] ? DIV_LD : MUL_LD;
   assign unused_f3 = ^bus.id_instr[13:12];
   always_comb begin
      dec = '0;
      if (bus.id_valid) begin
         dec.valid   = 1'b1;
         dec.rd      = bus.id_instr[11:7];
         dec.rs1     = bus.id_instr[19:15];
         dec.rs2     = bus.id_instr[24:20];
         dec.illegal = illegal;
         if (!illegal) begin
            dec.alusrc   = is_ld | is_st | is_imm | is_jalr | is_lui | is_aui;
            dec.regwrite = is_r | is_ld | is_imm | is_jal | is_jalr | is_lui | is_aui;
            dec.memtoreg = is_ld;
            dec.memread  = is_ld;
            dec.memwrite = is_st;
            dec.branch   = is_br;
            dec.jump     = is_jal;
            dec.jalrsel  = is_jalr;
            dec.aluop    = is_br ? 2'b01 : (is_r | is_imm | is_jal | is_jalr) ? 2'b10 : 2'b00;
            dec.lui      = is_lui;
            dec.auipc    = is_aui;
            dec.muldiv   = md;
         end
      end
   end
   assign busy = state == BUSY;
   // Only a live load with a non-zero destination can starve a real source operand.
   assign luse = ex.valid & ex.memread & (ex.rd != 5'd0) & bus.id_valid
                 & ((use1 & (bus.id_instr[19:15] == ex.rd)) | (use2 & (bus.id_instr[24:20] == ex.rd)));
   assign bus.id_ready = !reset & (bus.flush | (!busy & !luse));
   assign bus.ex_hold  = busy & !bus.flush;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ex    <= '0;
         state <= IDLE;
         cnt   <= '0;
      end else if (bus.flush) begin
         ex    <= '0;
         state <= IDLE;
         cnt   <= '0;
      end else if (busy) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) state <= IDLE;
      end else if (luse) begin
         ex <= '0;
      end else begin
         ex <= dec;
         if (dec.muldiv && ld != '0) begin
            state <= BUSY;
            cnt   <= ld;
         end
      end
   assign bus.ex_valid    = ex.valid;
   assign bus.ex_ALUSrc   = ex.alusrc;
   assign bus.ex_MemtoReg = ex.memtoreg;
   assign bus.ex_RegWrite = ex.regwrite;
   assign bus.ex_MemRead  = ex.memread;
   assign bus.ex_MemWrite = ex.memwrite;
   assign bus.ex_Branch   = ex.branch;
   assign bus.ex_JalrSel  = ex.jalrsel;
   assign bus.ex_Jump     = ex.jump;
   assign bus.ex_ALUOp    = ex.aluop;
   assign bus.ex_lui      = ex.lui;
   assign bus.ex_auipc    = ex.auipc;
   assign bus.ex_muldiv   = ex.muldiv;
   assign bus.ex_illegal  = ex.illegal;
   assign bus.ex_rd       = ex.rd;
   assign bus.ex_rs1      = ex.rs1;
   assign bus.ex_rs2      = ex.rs2;
endmodule

// File: tb/tb_id_ex_control_stage.sv
// tb_id_ex_control_stage: decode table sweep, stall corner sequences, randomized run vs reference model
module tb_id_ex_control_stage;
   localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011,
                          OP_BR = 7'b1100011, OP_IMM = 7'b0010011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
   // ctl bits: ALUSrc MemtoReg RegWrite MemRead MemWrite Branch JalrSel Jump ALUOp[1:0] lui auipc muldiv illegal
   typedef struct packed {
      logic       v;
      logic [13:0] c;
      logic [4:0] rd, rs1, rs2;
   } ex_t;
   typedef struct {
      logic [6:0]  op;
      logic [13:0] ctl;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0, failures = 0;
   vec_t vec[10];
   ex_t m;
   int stall;
   id_ex_control_stage_if b ();
   id_ex_control_stage_if b0 ();
   id_ex_control_stage dut (.clk(clk), .reset(reset), .bus(b));
   id_ex_control_stage #(.MULDIV_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                      logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction
   function automatic ex_t act();
      return {b.ex_valid, b.ex_ALUSrc, b.ex_MemtoReg, b.ex_RegWrite, b.ex_MemRead, b.ex_MemWrite,
              b.ex_Branch, b.ex_JalrSel, b.ex_Jump, b.ex_ALUOp, b.ex_lui, b.ex_auipc,
              b.ex_muldiv, b.ex_illegal, b.ex_rd, b.ex_rs1, b.ex_rs2};
   endfunction
   function automatic ex_t ref_dec(logic [31:0] ins);
      ex_t e = '0;
      e.v = 1'b1;
      e.rd = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.c = 14'b1;
      foreach (vec[k]) if (vec[k].op == ins[6:0]) e.c = vec[k].ctl;
      if (ins[6:0] == OP_R && ins[31:25] == 7'b0000001) e.c[1] = 1'b1;
      return e;
   endfunction
   function automatic bit hazard(ex_t e, logic v, logic [31:0] ins);
      bit u1 = ins[6:0] inside {OP_R, OP_LD, OP_ST, OP_BR, OP_IMM, OP_JALR};
      bit u2 = ins[6:0] inside {OP_R, OP_ST, OP_BR};
      return e.v && e.c[10] && e.rd != 0 && v &&
             ((u1 && ins[19:15] == e.rd) || (u2 && ins[24:20] == e.rd));
   endfunction
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run_md(input logic [31:0] ins, input int exp_hold, input string n);
      int cnt = 0;
      b.id_valid = 1'b1;
      b.id_instr = ins;
      tick();
      chk({n, "_muldiv"}, {b.ex_valid, b.ex_muldiv}, 2'b11);
      b.id_instr = mk(OP_IMM, 10, 0, 11, 0, 0);
      for (int i = 0; i < 100 && b.ex_hold; i++) begin
         chk({n, "_stall"}, b.id_ready, 1'b0);
         cnt++;
         tick();
      end
      chk({n, "_holds"}, cnt, exp_hold);
      chk({n, "_release"}, {b.ex_hold, b.id_ready}, 2'b01);
      tick();
      chk({n, "_next"}, {b.ex_valid, b.ex_rd}, {1'b1, 5'd10});
   endtask
   initial begin
      logic [31:0] ins;
      ex_t e;
      vec[0] = '{OP_R,    14'b00100000_10_0000};
      vec[1] = '{OP_LD,   14'b11110000_00_0000};
      vec[2] = '{OP_ST,   14'b10001000_00_0000};
      vec[3] = '{OP_BR,   14'b00000100_01_0000};
      vec[4] = '{OP_IMM,  14'b10100000_10_0000};
      vec[5] = '{OP_JAL,  14'b00100001_10_0000};
      vec[6] = '{OP_JALR, 14'b10100010_10_0000};
      vec[7] = '{OP_LUI,  14'b10100000_00_1000};
      vec[8] = '{OP_AUI,  14'b10100000_00_0100};
      vec[9] = '{7'h7f,   14'b00000000_00_0001};
      b.flush = 1'b0; b.id_valid = 1'b1; b.id_instr = mk(OP_R, 1, 0, 2, 3, 0);
      b0.flush = 1'b0; b0.id_valid = 1'b0; b0.id_instr = '0;
      #12;
      chk("reset_state", {act(), b.id_ready, b.ex_hold}, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         b.id_instr = mk(vec[k].op, 7, 0, 8, 9, 0);
         tick();
         chk($sformatf("decode_%0d", k), act(), {1'b1, vec[k].ctl, 5'd7, 5'd8, 5'd9});
      end
      b.id_valid = 1'b0;
      tick();
      chk("idle_bubble", act(), '0);
      b.id_valid = 1'b1;
      b.id_instr = mk(OP_LD, 5, 2, 1, 0, 0);
      tick();
      b.id_instr = mk(OP_R, 6, 0, 5, 1, 0);
      #1 chk("lu_stall", b.id_ready, 1'b0);
      tick();
      chk("lu_bubble", {b.ex_valid, b.ex_RegWrite, b.id_ready}, 3'b001);
      tick();
      chk("lu_after", {b.ex_valid, b.ex_rd, b.ex_rs1}, {1'b1, 5'd6, 5'd5});
      b.id_instr = mk(OP_LD, 0, 2, 1, 0, 0);
      tick();
      b.id_instr = mk(OP_R, 6, 0, 0, 1, 0);
      #1 chk("lu_x0_nostall", b.id_ready, 1'b1);
      tick();
      chk("lu_x0_next", {b.ex_valid, b.ex_rd}, {1'b1, 5'd6});
      run_md(mk(OP_R, 3, 0, 1, 2, 7'b1), 3, "mul");
      run_md(mk(OP_R, 3, 4, 1, 2, 7'b1), 32, "div");
      b.id_instr = mk(OP_R, 3, 5, 1, 2, 7'b1);
      tick();
      b.id_instr = mk(OP_IMM, 12, 0, 1, 0, 0);
      repeat (12) tick();
      chk("flush_busy_pre", {b.ex_hold, b.id_ready}, 2'b10);
      b.flush = 1'b1;
      #1 chk("flush_ready", b.id_ready, 1'b1);
      tick();
      b.flush = 1'b0;
      b.id_valid = 1'b0;
      #1 chk("flush_idle", {b.ex_valid, b.ex_hold, b.id_ready}, 3'b001);
      tick();
      chk("flush_stays_idle", {b.ex_valid, b.ex_hold}, 2'b00);
      b.id_valid = 1'b1;
      b.id_instr = mk(OP_LD, 5, 2, 1, 0, 0);
      tick();
      b.id_instr = mk(OP_R, 6, 0, 5, 1, 0);
      b.flush = 1'b1;
      #1 chk("flush_lu_ready", b.id_ready, 1'b1);
      tick();
      b.flush = 1'b0;
      #1 chk("flush_lu_nostall", {b.ex_valid, b.id_ready}, 2'b01);
      tick();
      chk("flush_lu_next", {b.ex_valid, b.ex_rd}, {1'b1, 5'd6});
      b0.id_valid = 1'b1;
      b0.id_instr = mk(OP_R, 3, 0, 1, 2, 7'b1);
      tick();
      b0.id_valid = 1'b0;
      chk("nomd_illegal", {b0.ex_valid, b0.ex_illegal, b0.ex_muldiv, b0.ex_RegWrite,
                           b0.ex_hold, b0.id_ready}, 6'b110001);
      b.id_instr = mk(OP_R, 3, 4, 1, 2, 7'b1);
      tick();
      b.id_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("areset_pre", b.ex_hold, 1'b1);
      reset = 1'b1;
      #1 chk("areset_now", {act(), b.ex_hold, b.id_ready}, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      b.id_valid = 1'b1;
      b.id_instr = mk(OP_IMM, 4, 0, 2, 0, 0);
      tick();
      chk("areset_latency", act(), {1'b1, vec[4].ctl, 5'd4, 5'd2, 5'd0});
      b.id_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m = '0;
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [6:0] f7;
         logic [6:0] op;
         op = vec[$urandom_range(9)].op;
         f7 = ($urandom_range(2) == 0) ? 7'b0000001 : ($urandom_range(1) ? 7'b0100000 : 7'b0);
         b.flush = ($urandom_range(15) == 0);
         b.id_valid = ($urandom_range(3) != 0);
         b.id_instr = mk(op, 5'($urandom_range(3)), 3'($urandom_range(7)),
                         5'($urandom_range(3)), 5'($urandom_range(3)), f7);
         @(negedge clk);
         ins = b.id_instr;
         chk("random", {act(), b.id_ready, b.ex_hold},
             {m, b.flush | (stall == 0 && !hazard(m, b.id_valid, ins)), stall > 0 && !b.flush});
         if (b.flush) begin
            m = '0;
            stall = 0;
         end else if (stall > 0) stall--;
         else if (hazard(m, b.id_valid, ins)) m = '0;
         else if (b.id_valid) begin
            e = ref_dec(ins);
            m = e;
            if (e.c[1]) stall = (ins[14] ? 33 : 4) - 1;
         end else m = '0;
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/id_ex_control_stage.md
# id_ex_control_stage

Parametrised successor to the pipeline's combinational opcode controller. It decodes the full 32-bit instruction in ID and drives the same control bundle plus LUI/AUIPC/M-extension controls. The bundle is registered into the ID/EX pipeline register. The block also owns the ID-stage stall logic: a load-use bubble and a multi-cycle MUL/DIV busy FSM, with flush from branch/jump resolution in EX.

## Interface
- MULDIV_EN, 1: 1 decodes R-type funct7=0000001 as MUL/DIV; 0 flags it illegal.
- MUL_CYCLES, 4: cycles a MUL-class op (funct3[2]=0) occupies EX; must be ≥1.
- DIV_CYCLES, 33: cycles a DIV/REM op (funct3[2]=1) occupies EX; must be ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  id_instr holds a live instruction.
- id_instr  in  32  instruction in ID.
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX.
- id_ready  out  1  ID instruction is consumed at this edge (0 = IF/ID must hold).
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_hold  out  1  ID/EX contents are held this cycle (MUL/DIV busy).
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_JalrSel, ex_Jump  out  1 each  registered control bundle.
- ex_ALUOp  out  2  00 load/store/LUI/AUIPC, 01 branch, 10 R/I/JAL/JALR.
- ex_lui, ex_auipc  out  1 each  ALU operand A is 0 / PC.
- ex_muldiv  out  1  EX op goes to the multi-cycle unit.
- ex_illegal  out  1  unrecognised opcode (all other controls 0).
- ex_rd, ex_rs1, ex_rs2  out  5 each  register fields.

## Operation
- Opcodes: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011, OP-IMM 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- ALUSrc is set for LOAD, STORE, OP-IMM, JALR, LUI and AUIPC.
- RegWrite is set for R, LOAD, OP-IMM, JAL, JALR, LUI and AUIPC. MemtoReg and MemRead are set for LOAD only. MemWrite is set for STORE only.
- Branch is set for BRANCH, Jump for JAL, JalrSel for JALR.
- rs1 is used by R, LOAD, STORE, BRANCH, OP-IMM and JALR. rs2 is used by R, STORE and BRANCH.
- Load-use hazard: ex_valid & ex_MemRead & ex_rd≠0 & id_valid & (ex_rd equals a used rs).
  - Response: id_ready=0 and a bubble is loaded into EX (ex_valid=0, all controls 0).
- Busy FSM, states IDLE and BUSY, with down-counter cnt of width clog2(max cycles)+1.
  - Loading a muldiv with C>1 cycles sets cnt=C-1 and moves to BUSY.
  - In BUSY: ex_hold=1, id_ready=0, EX register unchanged, cnt decrements each edge. The transition at cnt==1 goes to IDLE with cnt=0.
- Next-EX priority: flush > BUSY hold > load-use bubble > load of the decoded ID instruction (ex_valid=id_valid).
- Flush clears ex_valid and all controls, forces IDLE and cnt=0, and sets id_ready=1 (the ID instruction is discarded by the fetch logic).
- An illegal opcode loads ex_valid=1, ex_illegal=1, and all other controls 0.

## Timing
- Reset: all ex_* outputs 0, FSM IDLE, cnt 0, id_ready 0 while reset is high.
- Decode latency is 1 cycle: the ID instruction at edge N appears on ex_* after edge N.
- id_ready and ex_hold are combinational from state, EX contents, id_instr and flush.
- A MUL/DIV stays in EX for exactly C cycles, so ID stalls for C-1 cycles; C=1 never enters BUSY.
- A load-use stall costs exactly 1 cycle. A dependent instruction stalled behind BUSY is re-checked against EX when BUSY ends.
- Reset asserted mid-BUSY returns to the reset state immediately, with no clock needed.

## Test plan
- Decode sweep: each of the 9 opcodes plus 1111111, id_valid=1 → next cycle the bundle matches the table. LUI gives ALUSrc=1, RegWrite=1, ALUOp=00, ex_lui=1. 1111111 gives ex_illegal=1 only.
- Load-use: lw x5 then add x6,x5,x1 → one cycle with id_ready=0 and ex_valid=0, then the add in EX. With lw x0 instead: no stall.
- MUL, DIV_CYCLES default: mul x3,x1,x2 → ex_hold=1 and id_ready=0 for 3 cycles, then the next instruction enters. div → 32 hold cycles.
- Flush priority: flush=1 while BUSY with cnt=20 → next cycle ex_valid=0, IDLE, id_ready=1. flush together with a load-use hazard → bubble, no extra stall.
- MULDIV_EN=0: mul encoding → ex_illegal=1, no BUSY.
- Async reset asserted mid-BUSY between edges → outputs 0 immediately. After release, the first valid instruction decodes with 1-cycle latency.
